// File: rtl/vram_wr_sched_pkg.sv
// vram_sched_pkg: shared types, region sizes and FSM encodings for the VRAM port-B write scheduler
package vram_sched_pkg;
    localparam int AW_DEF  = 12;
    localparam int DW_DEF  = 64;
    localparam int BEW_DEF = 8;
    localparam int REGION_WORDS [4] = '{2048, 4096, 512, 256};
    typedef enum logic [1:0] {TIL = 2'd0, PAT = 2'd1, PAL = 2'd2, SPR = 2'd3} region_e;
    typedef struct packed {
        region_e              region;
        logic [AW_DEF-1:0]    addr;
        logic [DW_DEF-1:0]    data;
        logic [BEW_DEF-1:0]   byteena;
    } fifo_entry_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    function automatic logic [3:0] onehot4(logic [1:0] r);
        return 4'b0001 << r;
    endfunction
endpackage

// File: rtl/vram_wr_sched_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count; storage is not reset, pointers are
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        rd_d  = rd_q + PW'(pop);
        wr_d  = wr_q + PW'(push);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/vram_wr_sched.sv
// vram_wr_sched: queues CPU writes and region fills, committing them to VRAM port B only inside the vblank/immediate window
module vram_wr_sched
    import vram_sched_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int BEW       = BEW_DEF,
    parameter int TIL_WORDS = REGION_WORDS[0],
    parameter int PAT_WORDS = REGION_WORDS[1],
    parameter int PAL_WORDS = REGION_WORDS[2],
    parameter int SPR_WORDS = REGION_WORDS[3]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [1:0]                   wr_region,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DW-1:0]                wr_data,
    input  logic [BEW-1:0]               wr_byteena,
    input  logic                         fill_start,
    input  logic [1:0]                   fill_region,
    input  logic [DW-1:0]                fill_data,
    output logic                         fill_busy,
    input  logic                         vblank,
    input  logic                         immediate,
    output logic [AW-1:0]                vram_addr_b,
    output logic [DW-1:0]                vram_wrdata_b,
    output logic [BEW-1:0]               vram_byteena_b,
    output logic [3:0]                   vram_wren_b,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         err
);
    localparam int CW = $clog2(DEPTH + 1);
    fifo_entry_t in_e, out_e;
    logic window, push, pop, fill_acc, in_range, pop_ok, fill_go, fill_last;
    logic [1:0] state_q, state_d, fill_region_q, fill_region_d;
    logic [AW-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic [DW-1:0] fill_data_q, fill_data_d, wrdata_q, wrdata_d;
    logic [BEW-1:0] be_q, be_d;
    logic [3:0] wren_q, wren_d;
    logic [CW-1:0] barrier_q, barrier_d;
    logic fill_pend_q, fill_pend_d, err_q, err_d;

    function automatic logic [AW:0] words(logic [1:0] r);
        return r == 2'd0 ? (AW+1)'(TIL_WORDS) : r == 2'd1 ? (AW+1)'(PAT_WORDS) :
               r == 2'd2 ? (AW+1)'(PAL_WORDS) : (AW+1)'(SPR_WORDS);
    endfunction

    sync_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_e),
        .dout  (out_e),
        .count (fifo_count)
    );

    assign wr_ready = fifo_count < CW'(DEPTH);
    always_comb begin
        in_e.region  = region_e'(wr_region);
        in_e.addr    = wr_addr;
        in_e.data    = wr_data;
        in_e.byteena = wr_byteena;
        window    = vblank | immediate;
        push      = wr_valid & wr_ready;
        fill_acc  = fill_start & ~fill_pend_q;
        in_range  = {1'b0, out_e.addr} < words(out_e.region);
        pop_ok    = window & (fifo_count != '0) & (~fill_pend_q | (barrier_q != '0));
        fill_go   = window & fill_pend_q & (barrier_q == '0);
        fill_last = {1'b0, cnt_q} == words(fill_region_q) - (AW+1)'(1);
        pop           = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wrdata_d      = wrdata_q;
        be_d          = be_q;
        wren_d        = '0;
        fill_pend_d   = fill_pend_q;
        fill_region_d = fill_region_q;
        fill_data_d   = fill_data_q;
        err_d         = err_q | (fill_start & fill_pend_q);
        if (state_q == ST_FILL) begin
            if (window) begin
                wren_d   = onehot4(fill_region_q);
                addr_d   = cnt_q;
                wrdata_d = fill_data_q;
                be_d     = '1;
                cnt_d    = fill_last ? '0 : cnt_q + AW'(1);
                state_d  = fill_last ? ST_IDLE : ST_FILL;
                fill_pend_d = ~fill_last;
            end
        end else if (state_q == ST_IDLE && fill_go) begin
            state_d = ST_FILL;
        end else if (pop_ok) begin
            // out-of-range entries are consumed silently: no strobe, port-B bus holds
            pop     = 1'b1;
            state_d = ST_DRAIN;
            wren_d  = in_range ? onehot4(out_e.region) : 4'b0000;
            addr_d   = in_range ? out_e.addr : addr_q;
            wrdata_d = in_range ? out_e.data : wrdata_q;
            be_d     = in_range ? out_e.byteena : be_q;
            err_d    = err_d | ~in_range;
        end else begin
            state_d = ST_IDLE;
        end
        if (fill_acc) begin
            fill_pend_d   = 1'b1;
            fill_region_d = fill_region;
            fill_data_d   = fill_data;
        end
        barrier_d = fill_acc ? fifo_count - CW'(pop) :
                    (pop && barrier_q != '0) ? barrier_q - CW'(1) : barrier_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wrdata_q      <= '0;
            be_q          <= '0;
            wren_q        <= '0;
            fill_pend_q   <= 1'b0;
            fill_region_q <= '0;
            fill_data_q   <= '0;
            barrier_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wrdata_q      <= wrdata_d;
            be_q          <= be_d;
            wren_q        <= wren_d;
            fill_pend_q   <= fill_pend_d;
            fill_region_q <= fill_region_d;
            fill_data_q   <= fill_data_d;
            barrier_q     <= barrier_d;
            err_q         <= err_d;
        end
    end

    assign vram_addr_b    = addr_q;
    assign vram_wrdata_b  = wrdata_q;
    assign vram_byteena_b = be_q;
    assign vram_wren_b    = wren_q;
    assign fill_busy      = fill_pend_q;
    assign err            = err_q;
endmodule
